// File: rtl/tx_packet_sequencer.sv
// Transmit packet sequencer: walks SYNC, PID, payload, CRC16 and EOP segments,
// steering the bit/byte timer and the byte shifter for one outgoing packet.
module tx_packet_sequencer #(
  parameter int MAX_BYTES = 64,
  parameter int OCC_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [1:0]       tx_packet,
  input  logic [OCC_W-1:0] buffer_occupancy,
  input  logic [7:0]       tx_data,
  output logic             get_tx_data,
  input  logic             shift_enable,
  input  logic             packet_done,
  output logic             enable_timer,
  output logic             clear_8,
  output logic             clear_64,
  output logic [3:0]       roll_val,
  output logic             load_byte,
  output logic [7:0]       byte_out,
  output logic             tx_eop,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_error
);

  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, DONE} state_t;

  localparam logic [OCC_W-1:0] MAX_OCC = OCC_W'(MAX_BYTES);

  state_t           state, state_nxt, seg;
  logic             seg_load;
  logic             start_q, start_nxt;
  logic             pd_q, pd_edge;
  logic [1:0]       pkt_q, pkt_nxt;
  logic [OCC_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [15:0]      crc, crc_nxt;
  logic [7:0]       byte_q, byte_nxt;
  logic [3:0]       roll_q, roll_nxt;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] pid_byte(input logic [1:0] p);
    case (p)
      2'b00:   return 8'hC3;
      2'b01:   return 8'hD2;
      2'b10:   return 8'h5A;
      default: return 8'h1E;
    endcase
  endfunction

  // A stale packet_done level from the previous segment never re-triggers.
  assign pd_edge  = packet_done & ~pd_q;
  assign byte_out = byte_nxt;
  assign roll_val = roll_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      pd_q     <= 1'b0;
      pkt_q    <= 2'b00;
      byte_cnt <= '0;
      crc      <= 16'h0000;
      byte_q   <= 8'h00;
      roll_q   <= 4'd0;
    end else begin
      state    <= state_nxt;
      start_q  <= start_nxt;
      pd_q     <= packet_done;
      pkt_q    <= pkt_nxt;
      byte_cnt <= byte_cnt_nxt;
      crc      <= crc_nxt;
      byte_q   <= byte_nxt;
      roll_q   <= roll_nxt;
    end
  end

  // seg names the segment whose load cycle is the current cycle, if any.
  always_comb begin
    state_nxt    = state;
    start_nxt    = 1'b0;
    pkt_nxt      = pkt_q;
    byte_cnt_nxt = byte_cnt;
    crc_nxt      = crc;
    byte_nxt     = byte_q;
    roll_nxt     = roll_q;
    seg          = IDLE;
    seg_load     = 1'b0;
    get_tx_data  = 1'b0;
    tx_error     = 1'b0;
    tx_done      = 1'b0;
    tx_eop       = 1'b0;
    clear_8      = 1'b0;
    clear_64     = 1'b0;
    load_byte    = 1'b0;
    enable_timer = 1'b0;
    tx_busy      = (state != IDLE);

    case (state)
      IDLE: begin
        if (tx_start) begin
          if (tx_packet == 2'b00 && buffer_occupancy > MAX_OCC) begin
            tx_error = 1'b1;
          end else begin
            state_nxt    = SYNC;
            start_nxt    = 1'b1;
            pkt_nxt      = tx_packet;
            byte_cnt_nxt = (tx_packet == 2'b00) ? buffer_occupancy : '0;
          end
        end
      end
      SYNC: begin
        if (start_q)      begin seg = SYNC; seg_load = 1'b1; end
        else if (pd_edge) begin seg = PID;  seg_load = 1'b1; end
      end
      PID: begin
        if (pd_edge) begin
          seg_load = 1'b1;
          if (pkt_q != 2'b00)      seg = EOP;
          else if (byte_cnt == '0) seg = CRC_LO;
          else                     seg = DATA;
        end
      end
      DATA: begin
        if (pd_edge) begin
          seg_load = 1'b1;
          seg      = (byte_cnt == '0) ? CRC_LO : DATA;
        end
      end
      CRC_LO: if (pd_edge) begin seg = CRC_HI; seg_load = 1'b1; end
      CRC_HI: if (pd_edge) begin seg = EOP;    seg_load = 1'b1; end
      EOP: begin
        if (pd_edge) state_nxt = DONE;
        else         tx_eop    = 1'b1;
      end
      DONE: begin
        tx_done   = 1'b1;
        state_nxt = IDLE;
        byte_nxt  = 8'h00;
        roll_nxt  = 4'd0;
      end
      default: state_nxt = IDLE;
    endcase

    // An empty FIFO where a payload byte is due truncates the packet straight to EOP.
    if (seg_load && seg == DATA && buffer_occupancy == '0) begin
      seg      = EOP;
      tx_error = 1'b1;
    end

    if (seg_load) begin
      state_nxt = seg;
      clear_8   = 1'b1;
      clear_64  = 1'b1;
      roll_nxt  = 4'd8;
      load_byte = 1'b1;
      case (seg)
        SYNC: byte_nxt = 8'h80;
        PID: begin
          byte_nxt = pid_byte(pkt_q);
          crc_nxt  = 16'hFFFF;
        end
        DATA: begin
          byte_nxt     = tx_data;
          get_tx_data  = 1'b1;
          crc_nxt      = crc16_byte(crc, tx_data);
          byte_cnt_nxt = byte_cnt - 1'b1;
        end
        CRC_LO: byte_nxt = ~crc[7:0];
        CRC_HI: byte_nxt = ~crc[15:8];
        EOP: begin
          byte_nxt  = 8'h00;
          roll_nxt  = 4'd2;
          load_byte = 1'b0;
          tx_eop    = 1'b1;
        end
        default: ;
      endcase
    end

    enable_timer = (state inside {SYNC, PID, DATA, CRC_LO, CRC_HI, EOP}) &&
                   !seg_load && !(state == EOP && pd_edge);
  end

endmodule

// File: tb/tb_tx_packet_sequencer.sv
// Bench for tx_packet_sequencer: timer and FIFO models around the DUT, with a
// packet-level reference built from the protocol rules.
module tb_tx_packet_sequencer;
  localparam int MAX_BYTES = 64;
  localparam int OCC_W     = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             tx_start;
  logic [1:0]       tx_packet;
  logic [OCC_W-1:0] buffer_occupancy;
  logic [7:0]       tx_data;
  logic             get_tx_data, shift_enable, packet_done;
  logic             enable_timer, clear_8, clear_64, load_byte;
  logic [3:0]       roll_val;
  logic [7:0]       byte_out;
  logic             tx_eop, tx_busy, tx_done, tx_error;

  always #5 clk = ~clk;

  tx_packet_sequencer #(.MAX_BYTES(MAX_BYTES), .OCC_W(OCC_W)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_packet(tx_packet),
    .buffer_occupancy(buffer_occupancy), .tx_data(tx_data), .get_tx_data(get_tx_data),
    .shift_enable(shift_enable), .packet_done(packet_done), .enable_timer(enable_timer),
    .clear_8(clear_8), .clear_64(clear_64), .roll_val(roll_val), .load_byte(load_byte),
    .byte_out(byte_out), .tx_eop(tx_eop), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_error(tx_error)
  );

  // Timer: strobe every 8 enabled clocks, done level held until the next strobe.
  logic [2:0] t_bit;
  logic [3:0] t_seg;
  logic       t_pd;
  assign shift_enable = enable_timer && !clear_8 && (t_bit == 3'd7);
  assign packet_done  = t_pd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_bit <= 3'd0;
      t_seg <= 4'd0;
      t_pd  <= 1'b0;
    end else begin
      if (clear_8)           t_bit <= 3'd0;
      else if (enable_timer) t_bit <= t_bit + 3'd1;
      if (clear_64)          t_seg <= 4'd0;
      else if (shift_enable) t_seg <= t_seg + 4'd1;
      if (shift_enable)      t_pd  <= ((t_seg + 4'd1) == roll_val);
    end
  end

  typedef struct {
    logic [1:0] pkt;
    int         len;
    int         avail;
    bit         poke;
    int         exp_loads;
    int         exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo[$];
  logic [7:0] pay[128];
  int         fifo_len0, cut, pops_done;
  bit         pop_pend;

  logic [7:0] got[$];
  int         got_cyc[$];
  int         cyc, pop_n, pop_bad, eop_n, done_n, done_cyc, err_n, busy_n;
  bit         en_seen;

  logic [7:0] exp_q[$];
  int         exp_pops, exp_err;
  bit         exp_abort;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic fifo_update();
    bit starve;
    starve = (cut < fifo_len0) && (pops_done >= cut);
    buffer_occupancy = starve ? '0 : OCC_W'(fifo.size());
    tx_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic sample();
    pop_pend = get_tx_data;
    if (load_byte) begin
      got.push_back(byte_out);
      got_cyc.push_back(cyc);
    end
    if (get_tx_data) pop_n++;
    if (get_tx_data && !load_byte) pop_bad++;
    if (tx_eop) eop_n++;
    if (tx_done) begin done_n++; done_cyc = cyc; end
    if (tx_error) err_n++;
    if (tx_busy) busy_n++;
    if (enable_timer) en_seen = 1'b1;
    cyc++;
  endtask

  task automatic tick();
    sample();
    @(posedge clk);
    #1;
    if (pop_pend) begin
      if (fifo.size() > 0) void'(fifo.pop_front());
      pops_done++;
    end
    fifo_update();
    @(negedge clk);
  endtask

  // Reference CRC in the MSB-first 0x8005 form, bit-reversed at the end.
  function automatic logic [15:0] ref_crc(input logic [7:0] bytes[$]);
    logic [15:0] c, r;
    logic        fb;
    c = 16'hFFFF;
    foreach (bytes[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ bytes[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    return r;
  endfunction

  task automatic build_model(input logic [1:0] pkt, input int len, input int avail);
    logic [7:0] data[$];
    logic [7:0] pids[4];
    logic [15:0] c;
    pids = '{8'hC3, 8'hD2, 8'h5A, 8'h1E};
    exp_q.delete();
    exp_pops  = 0;
    exp_err   = 0;
    exp_abort = 1'b0;
    if (pkt == 2'b00 && len > MAX_BYTES) begin
      exp_err   = 1;
      exp_abort = 1'b1;
      return;
    end
    exp_q.push_back(8'h80);
    exp_q.push_back(pids[pkt]);
    if (pkt != 2'b00) return;
    for (int i = 0; i < len; i++) begin
      if (i >= avail) begin
        exp_err = 1;
        break;
      end
      data.push_back(pay[i]);
      exp_q.push_back(pay[i]);
      exp_pops++;
    end
    if (exp_err == 0) begin
      c = ref_crc(data);
      exp_q.push_back(~c[7:0]);
      exp_q.push_back(~c[15:8]);
    end
  endtask

  task automatic apply_stimulus(input string name, input logic [1:0] pkt, input int len,
                                input int avail, input bit poke);
    int budget, bad_gap, k;
    build_model(pkt, len, avail);
    fifo.delete();
    for (int i = 0; i < len; i++) fifo.push_back(pay[i]);
    fifo_len0 = len;
    cut       = avail;
    pops_done = 0;
    pop_pend  = 1'b0;
    fifo_update();
    got.delete();
    got_cyc.delete();
    cyc = 0; pop_n = 0; pop_bad = 0; eop_n = 0; done_n = 0; done_cyc = 0;
    err_n = 0; busy_n = 0; en_seen = 1'b0;

    tx_packet = pkt;
    tx_start  = 1'b1;
    tick();
    tx_start = 1'b0;
    budget = 65 * (exp_q.size() + 2) + 100;
    k = 0;
    while (done_n == 0 && !(exp_abort && k > 20) && k < budget) begin
      if (poke && k == 100) begin tx_start = 1'b1; tx_packet = ~pkt; end
      if (poke && k == 101) begin tx_start = 1'b0; tx_packet = pkt; end
      tick();
      k++;
    end
    tx_start  = 1'b0;
    tx_packet = pkt;
    repeat (2) tick();

    check_output({name, "_nbytes"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check_output($sformatf("%s_byte%0d", name, i), got[i], exp_q[i]);
    check_output({name, "_pops"}, pop_n, exp_pops);
    check_output({name, "_pop_no_load"}, pop_bad, 0);
    check_output({name, "_err"}, err_n, exp_err);
    check_output({name, "_busy_end"}, tx_busy, 0);
    if (exp_abort) begin
      check_output({name, "_en_seen"}, en_seen, 0);
      check_output({name, "_busy_cnt"}, busy_n, 0);
      check_output({name, "_done"}, done_n, 0);
    end else begin
      check_output({name, "_done"}, done_n, 1);
      check_output({name, "_eop_len"}, eop_n, 17);
      bad_gap = 0;
      for (int i = 1; i < got_cyc.size(); i++)
        if (got_cyc[i] - got_cyc[i-1] != 65) bad_gap++;
      check_output({name, "_gap"}, bad_gap, 0);
      if (got_cyc.size() > 0)
        check_output({name, "_span"}, done_cyc - got_cyc[0], 65 * exp_q.size() + 18);
    end

    k = 0;
    while (tx_busy && k < 10000) begin tick(); k++; end
  endtask

  initial begin
    vec_t vecs[8];
    int   len, avail;
    logic [1:0] pkt;
    int   k;

    vecs[0] = '{2'b01,  0,  0, 1'b0,  2, 0};
    vecs[1] = '{2'b10,  0,  0, 1'b0,  2, 0};
    vecs[2] = '{2'b11,  0,  0, 1'b1,  2, 0};
    vecs[3] = '{2'b00,  0,  0, 1'b0,  4, 0};
    vecs[4] = '{2'b00,  3,  3, 1'b1,  7, 0};
    vecs[5] = '{2'b00, 65, 65, 1'b0,  0, 1};
    vecs[6] = '{2'b00, 64, 64, 1'b0, 68, 0};
    vecs[7] = '{2'b00,  2,  1, 1'b0,  3, 1};

    rst = 1'b1; tx_start = 1'b0; tx_packet = 2'b00;
    fifo_len0 = 0; cut = 0; pops_done = 0; pop_pend = 1'b0;
    fifo_update();
    repeat (3) @(negedge clk);
    check_output("reset_outputs",
                 {get_tx_data, enable_timer, clear_8, clear_64, roll_val, load_byte,
                  byte_out, tx_eop, tx_busy, tx_done, tx_error}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 128; i++) pay[i] = 8'(i + 1);
    foreach (vecs[v]) begin
      apply_stimulus($sformatf("vec%0d", v), vecs[v].pkt, vecs[v].len, vecs[v].avail, vecs[v].poke);
      check_output($sformatf("vec%0d_tbl_loads", v), got.size(), vecs[v].exp_loads);
      check_output($sformatf("vec%0d_tbl_err", v), err_n, vecs[v].exp_err);
    end

    for (int r = 0; r < 12; r++) begin
      pkt = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 10);
      avail = len;
      if (len >= 2 && $urandom_range(0, 3) == 0) avail = $urandom_range(1, len - 1);
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
      apply_stimulus($sformatf("rnd%0d", r), pkt, len, avail, 1'b0);
    end

    // Asynchronous reset in the middle of a payload, then a clean ACK.
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    fifo.delete();
    for (int i = 0; i < 4; i++) fifo.push_back(pay[i]);
    fifo_len0 = 4; cut = 4; pops_done = 0;
    fifo_update();
    tx_packet = 2'b00;
    tx_start  = 1'b1;
    tick();
    tx_start = 1'b0;
    k = 0;
    while (pops_done < 2 && k < 1000) begin tick(); k++; end
    check_output("mid_reset_reached_data", pops_done, 2);
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    check_output("mid_reset_outputs",
                 {get_tx_data, enable_timer, clear_8, clear_64, roll_val, load_byte,
                  byte_out, tx_eop, tx_busy, tx_done, tx_error}, 0);
    @(negedge clk);
    pop_pend = 1'b0;
    fifo.delete();
    fifo_len0 = 0; cut = 0; pops_done = 0;
    fifo_update();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    apply_stimulus("post_reset_ack", 2'b01, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
